// File: rtl/imem_uart_loader.sv
// Boot loader: receives a little-endian program image over an 8N1 UART, writes it
// word by word into instruction memory and holds the CPU in reset until loading completes.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uart_rx,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_CNT_LO, LD_CNT_HI, LD_DATA, LD_WRITE, LD_DONE, LD_ERROR} ld_state_t;

  // ---------------- UART receiver ----------------
  logic             rx_meta, rx_sync;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Synchroniser resets to the idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync) rx_state_d = RX_START;
      end
      RX_START: if (clk_cnt_q == HALF_LAST) begin
        clk_cnt_d  = '0;
        bit_idx_d  = '0;
        rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (clk_cnt_q == BIT_LAST) begin
        clk_cnt_d = '0;
        shift_d   = {rx_sync, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (clk_cnt_q == BIT_LAST) begin
        clk_cnt_d    = '0;
        byte_valid_d = rx_sync;
        frame_err_d  = !rx_sync;
        rx_state_d   = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------- Image loader ----------------
  ld_state_t             ld_state_q, ld_state_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           lanes_q, lanes_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic [15:0]           n_words;
  logic                  last_word;

  assign n_words   = {shift_q, count_q[7:0]};
  assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, count_q};

  always_comb begin
    ld_state_d = ld_state_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    case (ld_state_q)
      LD_CNT_LO:
        if (frame_err_q) ld_state_d = LD_ERROR;
        else if (byte_valid_q) begin
          count_d[7:0] = shift_q;
          ld_state_d   = LD_CNT_HI;
        end
      LD_CNT_HI:
        if (frame_err_q) ld_state_d = LD_ERROR;
        else if (byte_valid_q) begin
          count_d[15:8] = shift_q;
          byte_idx_d    = '0;
          if ({1'b0, n_words} > MAX_WORDS) ld_state_d = LD_ERROR;
          else if (n_words == 16'd0)       ld_state_d = LD_DONE;
          else                             ld_state_d = LD_DATA;
        end
      LD_DATA:
        if (frame_err_q) ld_state_d = LD_ERROR;
        else if (byte_valid_q) begin
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            // Word is captured here so address/data are stable for the whole write cycle.
            wdata_d    = {shift_q, lanes_q};
            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
            ld_state_d = LD_WRITE;
          end else begin
            lanes_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
          end
        end
      LD_WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        byte_idx_d = '0;
        ld_state_d = last_word ? LD_DONE : LD_DATA;
      end
      LD_DONE, LD_ERROR:
        if (reload) begin
          count_d    = '0;
          word_cnt_d = '0;
          byte_idx_d = '0;
          ld_state_d = LD_CNT_LO;
        end
      default: ld_state_d = LD_ERROR;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_state_q <= LD_CNT_LO;
      count_q    <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      lanes_q    <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      ld_state_q <= ld_state_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
    end
  end

  assign imem_we    = (ld_state_q == LD_WRITE);
  assign cpu_reset  = (ld_state_q != LD_DONE);
  assign load_done  = (ld_state_q == LD_DONE);
  assign load_error = (ld_state_q == LD_ERROR);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: a 16-clock-per-bit instance for the protocol
// scenarios and a 4-clock-per-bit instance for the full 256-word image.
module tb_imem_uart_loader;
  localparam int CPB      = 16;
  localparam int CPB_FAST = 4;
  localparam int AW       = 8;

  logic          clock   = 1'b0;
  logic          reset   = 1'b0;
  logic          uart_rx = 1'b1;
  logic          reload  = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset, load_done, load_error;

  logic          f_rx     = 1'b1;
  logic          f_reload = 1'b0;
  logic          f_we;
  logic [AW-1:0] f_addr;
  logic [31:0]   f_wdata;
  logic          f_cpu_reset, f_done, f_error;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .uart_rx(uart_rx), .reload(reload),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  imem_uart_loader #(.CLKS_PER_BIT(CPB_FAST), .ADDR_WIDTH(AW)) dut_fast (
    .clock(clock), .reset(reset), .uart_rx(f_rx), .reload(f_reload),
    .imem_we(f_we), .imem_addr(f_addr), .imem_wdata(f_wdata),
    .cpu_reset(f_cpu_reset), .load_done(f_done), .load_error(f_error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t sb[$];
  wr_t sb_fast[$];
  wr_t exp_w, exp_f;

  int vectors       = 0;
  int miscompares   = 0;
  int cyc           = 0;
  int last_we_cyc   = -100;
  int done_rise_cyc = -100;
  int n_writes      = 0;
  int n_writes_fast = 0;
  logic rst_at_last_we = 1'b0;
  logic prev_done      = 1'b0;
  logic [AW-1:0] f_last_addr = '0;

  // Write monitor: every imem_we pulse is checked against the head of the scoreboard.
  always @(negedge clock) begin
    cyc++;
    if (load_done && !prev_done) done_rise_cyc = cyc;
    prev_done = load_done;
    if (imem_we) begin
      n_writes++;
      last_we_cyc    = cyc;
      rst_at_last_we = cpu_reset;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected: got addr=%0h data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        exp_w = sb.pop_front();
        if (imem_addr !== exp_w.addr || imem_wdata !== exp_w.data) begin
          miscompares++;
          $display("FAIL write: got addr=%0h data=%h, expected addr=%0h data=%h",
                   imem_addr, imem_wdata, exp_w.addr, exp_w.data);
        end
      end
    end
    if (f_we) begin
      n_writes_fast++;
      f_last_addr = f_addr;
      vectors++;
      if (sb_fast.size() == 0) begin
        miscompares++;
        $display("FAIL fast_write_unexpected: got addr=%0h data=%h, expected no write", f_addr, f_wdata);
      end else begin
        exp_f = sb_fast.pop_front();
        if (f_addr !== exp_f.addr || f_wdata !== exp_f.data) begin
          miscompares++;
          $display("FAIL fast_write: got addr=%0h data=%h, expected addr=%0h data=%h",
                   f_addr, f_wdata, exp_f.addr, exp_f.data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a);
    wr_t t;
    t.addr = a;
    t.data = w;
    sb.push_back(t);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_byte_fast(input logic [7:0] b);
    f_rx = 1'b0;
    repeat (CPB_FAST) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      f_rx = b[i];
      repeat (CPB_FAST) @(negedge clock);
    end
    f_rx = 1'b1;
    repeat (CPB_FAST) @(negedge clock);
  endtask

  task automatic send_word_fast(input logic [31:0] w, input logic [AW-1:0] a);
    wr_t t;
    t.addr = a;
    t.data = w;
    sb_fast.push_back(t);
    for (int i = 0; i < 4; i++) send_byte_fast(w[8*i +: 8]);
  endtask

  task automatic do_reload();
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    #1;
  endtask

  task automatic wait_status(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (load_done || load_error) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    vectors++;
    if ({imem_we, cpu_reset, load_done, load_error} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_flags: got we/rst/done/err=%b, expected 0100", {imem_we, cpu_reset, load_done, load_error});
    end
    vectors++;
    if (imem_addr !== '0 || imem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%0h data=%h, expected 0/0", imem_addr, imem_wdata);
    end
    vectors++;
    if ({f_we, f_cpu_reset, f_done, f_error} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_fast: got we/rst/done/err=%b, expected 0100", {f_we, f_cpu_reset, f_done, f_error});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    vectors++;
    if ({cpu_reset, load_done, load_error} !== 3'b100) begin
      miscompares++;
      $display("FAIL post_reset: got rst/done/err=%b, expected 100", {cpu_reset, load_done, load_error});
    end
  endtask

  task automatic test_glitch();
    bit ok;
    @(negedge clock);
    uart_rx = 1'b0;
    repeat (3) @(negedge clock);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(negedge clock);
    #1;
    vectors++;
    if ({cpu_reset, load_done, load_error} !== 3'b100 || n_writes !== 0) begin
      miscompares++;
      $display("FAIL glitch_idle: got rst/done/err=%b writes=%0d, expected 100 writes=0",
               {cpu_reset, load_done, load_error}, n_writes);
    end
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hDEADBEEF, 8'h00);
    wait_status(200, ok);
    vectors++;
    if (!ok || {cpu_reset, load_done, load_error} !== 3'b010 || n_writes !== 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_then_load: got ok=%0b rst/done/err=%b writes=%0d pending=%0d, expected ok=1 010 writes=1 pending=0",
               ok, {cpu_reset, load_done, load_error}, n_writes, sb.size());
    end
  endtask

  task automatic test_two_words();
    bit ok;
    int base;
    do_reload();
    vectors++;
    if ({cpu_reset, load_done, load_error} !== 3'b100) begin
      miscompares++;
      $display("FAIL reload_entry: got rst/done/err=%b, expected 100", {cpu_reset, load_done, load_error});
    end
    base = n_writes;
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00500513, 8'h00);
    send_word(32'h00A00593, 8'h01);
    wait_status(200, ok);
    vectors++;
    if (!ok || {cpu_reset, load_done, load_error} !== 3'b010 || n_writes - base != 2 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL two_words: got ok=%0b rst/done/err=%b writes=%0d pending=%0d, expected ok=1 010 writes=2 pending=0",
               ok, {cpu_reset, load_done, load_error}, n_writes - base, sb.size());
    end
    vectors++;
    if (done_rise_cyc != last_we_cyc + 1 || rst_at_last_we !== 1'b1) begin
      miscompares++;
      $display("FAIL release_timing: got done_cycle=%0d last_we_cycle=%0d rst_at_we=%0b, expected done=last_we+1 rst_at_we=1",
               done_rise_cyc, last_we_cyc, rst_at_last_we);
    end
  endtask

  task automatic test_zero_words();
    int base;
    do_reload();
    base = n_writes;
    send_byte(8'h00);
    send_byte(8'h00);
    #1;
    vectors++;
    if ({cpu_reset, load_done, load_error} !== 3'b010 || n_writes != base) begin
      miscompares++;
      $display("FAIL zero_words: got rst/done/err=%b writes=%0d, expected 010 writes=0",
               {cpu_reset, load_done, load_error}, n_writes - base);
    end
  endtask

  task automatic test_too_big();
    bit ok;
    int base;
    do_reload();
    base = n_writes;
    send_byte(8'h01);
    send_byte(8'h01);
    wait_status(50, ok);
    vectors++;
    if (!ok || {cpu_reset, load_done, load_error} !== 3'b101 || n_writes != base) begin
      miscompares++;
      $display("FAIL too_big: got ok=%0b rst/done/err=%b writes=%0d, expected ok=1 101 writes=0",
               ok, {cpu_reset, load_done, load_error}, n_writes - base);
    end
  endtask

  task automatic test_frame_error();
    bit ok;
    int base;
    do_reload();
    base = n_writes;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge clock);
    #1;
    vectors++;
    if ({cpu_reset, load_done, load_error} !== 3'b101 || n_writes != base) begin
      miscompares++;
      $display("FAIL frame_error: got rst/done/err=%b writes=%0d, expected 101 writes=0",
               {cpu_reset, load_done, load_error}, n_writes - base);
    end
    do_reload();
    vectors++;
    if ({cpu_reset, load_done, load_error} !== 3'b100) begin
      miscompares++;
      $display("FAIL error_reload: got rst/done/err=%b, expected 100", {cpu_reset, load_done, load_error});
    end
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h12345678, 8'h00);
    wait_status(200, ok);
    vectors++;
    if (!ok || {cpu_reset, load_done, load_error} !== 3'b010 || n_writes - base != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL error_recover: got ok=%0b rst/done/err=%b writes=%0d pending=%0d, expected ok=1 010 writes=1 pending=0",
               ok, {cpu_reset, load_done, load_error}, n_writes - base, sb.size());
    end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    int base;
    do_reload();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h05);
    uart_rx = 1'b0;
    repeat (CPB + 5) @(negedge clock);
    #1;
    reset   = 1'b0;
    uart_rx = 1'b1;
    #1;
    vectors++;
    if ({imem_we, cpu_reset, load_done, load_error} !== 4'b0100 || imem_addr !== '0 || imem_wdata !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got we/rst/done/err=%b addr=%0h data=%h, expected 0100 0 0",
               {imem_we, cpu_reset, load_done, load_error}, imem_addr, imem_wdata);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    base = n_writes;
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'hCAFEF00D, 8'h00);
    send_word(32'h0BADC0DE, 8'h01);
    wait_status(200, ok);
    vectors++;
    if (!ok || {cpu_reset, load_done, load_error} !== 3'b010 || n_writes - base != 2 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL reload_after_reset: got ok=%0b rst/done/err=%b writes=%0d pending=%0d, expected ok=1 010 writes=2 pending=0",
               ok, {cpu_reset, load_done, load_error}, n_writes - base, sb.size());
    end
  endtask

  task automatic test_full_image();
    bit ok;
    send_byte_fast(8'h00);
    send_byte_fast(8'h01);
    for (int i = 0; i < 256; i++) send_word_fast($urandom, AW'(i));
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (f_done || f_error) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok || {f_cpu_reset, f_done, f_error} !== 3'b010 || n_writes_fast != 256 || sb_fast.size() != 0) begin
      miscompares++;
      $display("FAIL full_image: got ok=%0b rst/done/err=%b writes=%0d pending=%0d, expected ok=1 010 writes=256 pending=0",
               ok, {f_cpu_reset, f_done, f_error}, n_writes_fast, sb_fast.size());
    end
    vectors++;
    if (f_last_addr !== 8'hFF) begin
      miscompares++;
      $display("FAIL full_last_addr: got %0h, expected ff", f_last_addr);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_two_words();
    test_zero_words();
    test_too_big();
    test_frame_error();
    test_reset_mid_word();
    test_full_image();
    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
